// File: rtl/dmem_store_if.sv
// Request/response bundle between the memory-stage controller and the data-memory responder.
// A request moves on a rising edge where req_valid && req_ready; the master holds req_* stable while req_valid waits for req_ready. rsp_valid is a one-cycle pulse with no ready.
interface dmem_store_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_store_responder.sv
// Data-memory responder: posted store buffer draining into a word RAM, loads served by forwarding or RAM.
// Optional macro DMEM_SB_FORWARD_EN: when defined, load hits forward from the buffer; otherwise they wait for the matching entries to drain.
module dmem_store_responder #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int SB_DEPTH = 4,
  parameter int READ_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  dmem_store_if.slave                   bus,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
  output logic                          sb_empty,
  output logic                          dbg_state
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = $clog2(SB_DEPTH + 1);
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic {IDLE = 1'b0, RD_BUSY = 1'b1} state_t;
  state_t state, state_n;

  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [DATA_W-1:0] ram     [2**ADDR_W];

  logic [PTR_W-1:0]  head, tail, idx;
  logic [CNT_W-1:0]  count;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] ram_q, fwd_data, fwd_q, rsp_rdata_q;
  logic              hit, hit_q, rsp_pend, rsp_valid_q;
  logic              req_ready, st_acc, ld_acc, drain, lat_done;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (sb_addr[idx] == bus.req_addr)) begin
        hit = 1'b1;
`ifdef DMEM_SB_FORWARD_EN
        fwd_data = sb_data[idx];
`endif
      end
    end
  end

  assign lat_done = (lat_cnt == '0);

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    st_acc    = 1'b0;
    ld_acc    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_we) begin
          req_ready = (count != CNT_W'(SB_DEPTH));
        end else begin
`ifdef DMEM_SB_FORWARD_EN
          req_ready = 1'b1;
`else
          req_ready = !hit;
`endif
        end
        st_acc = bus.req_valid && req_ready && bus.req_we;
        ld_acc = bus.req_valid && req_ready && !bus.req_we;
        if (ld_acc && !hit && (READ_LAT > 1)) state_n = RD_BUSY;
      end
      RD_BUSY: begin
        if (lat_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM reads and drains never share an edge, so a miss always sees up-to-date RAM.
  assign drain = (state == IDLE) && !ld_acc && (count != '0);

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign sb_count      = count;
  assign sb_empty      = (count == '0);
  assign dbg_state     = (state == RD_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      lat_cnt     <= '0;
      rsp_pend    <= 1'b0;
      hit_q       <= 1'b0;
      fwd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_pend    <= 1'b0;
      if (st_acc) tail <= tail + PTR_W'(1);
      if (drain)  head <= head + PTR_W'(1);
      if (st_acc && !drain)      count <= count + CNT_W'(1);
      else if (!st_acc && drain) count <= count - CNT_W'(1);
      if (rsp_pend || ((state == RD_BUSY) && lat_done)) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= hit_q ? fwd_q : ram_q;
      end
      if ((state == RD_BUSY) && !lat_done) lat_cnt <= lat_cnt - LAT_W'(1);
      if (ld_acc) begin
        hit_q <= hit;
        fwd_q <= fwd_data;
        if (hit || (READ_LAT == 1)) rsp_pend <= 1'b1;
        else                        lat_cnt  <= LAT_W'(READ_LAT - 1);
      end
    end
  end

  // Storage arrays carry no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (st_acc) begin
      sb_addr[tail] <= bus.req_addr;
      sb_data[tail] <= bus.req_wdata;
    end
    if (drain)  ram[sb_addr[head]] <= sb_data[head];
    if (ld_acc) ram_q <= ram[bus.req_addr];
  end
endmodule

// File: tb/tb_dmem_store_responder.sv
// Bench for dmem_store_responder: vector table, directed corner sequences and random traffic,
// with a program-order memory model feeding an expected-response queue.
module tb_dmem_store_responder;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int SD = 4;
  localparam int RL = 2;
`ifdef DMEM_SB_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [$clog2(SD+1)-1:0] sb_count;
  logic sb_empty;
  logic dbg_state;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  dmem_store_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_store_responder #(.ADDR_W(AW), .DATA_W(DW), .SB_DEPTH(SD), .READ_LAT(RL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sb_count (sb_count),
    .sb_empty (sb_empty),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [DW-1:0] ref_mem   [2**AW];
  bit            ref_known [2**AW];
  logic [DW-1:0] exp_q[$];
  bit            care_q[$];
  int            cyc_q[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
    int            exp_wait;
    int            exp_lat;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one request, waits (bounded) for acceptance, and updates the model.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int gap, input int exp_wait, input int exp_lat);
    int waits;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    #1;
    waits = 0;
    while (!bus.req_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (exp_wait >= 0) check("req_wait", waits, exp_wait);
    if (we) begin
      ref_mem[addr]   = data;
      ref_known[addr] = 1'b1;
    end else begin
      exp_q.push_back(ref_mem[addr]);
      care_q.push_back(ref_known[addr]);
      cyc_q.push_back(exp_lat >= 0 ? cyc + exp_lat : -1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: pop and compare on every response pulse.
  always @(negedge clk) begin
    logic [DW-1:0] d;
    bit            c;
    int            ec;
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%0h expected=none (cycle %0d)", bus.rsp_rdata, cyc);
      end else begin
        d  = exp_q.pop_front();
        c  = care_q.pop_front();
        ec = cyc_q.pop_front();
        if (c) check("rsp_data", bus.rsp_rdata, d);
        else   check("rsp_no_x", DW'($isunknown(bus.rsp_rdata)), 0);
        if (ec >= 0) check("rsp_latency", cyc, ec);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 1'b0;
    end
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    idle(3);
    check("rst_rsp_valid", DW'(bus.rsp_valid), 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_sb_count", DW'(sb_count), 0);
    check("rst_sb_empty", DW'(sb_empty), 1);
    check("rst_state", DW'(dbg_state), 0);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", DW'(bus.req_ready), 1);

    // Vector table: basic miss, forwarding/blocking, youngest match, busy back-pressure.
    vecs[0] = '{1'b0, 7'd5,  32'h0,        0, 0,           RL};
    vecs[1] = '{1'b1, 7'd3,  32'hDEADBEEF, 3, 0,           -1};
    vecs[2] = '{1'b0, 7'd3,  32'h0,        0, FWD ? 0 : 1, FWD ? 1 : RL};
    vecs[3] = '{1'b1, 7'd3,  32'h11,       4, 0,           -1};
    vecs[4] = '{1'b1, 7'd3,  32'h22,       0, 0,           -1};
    vecs[5] = '{1'b0, 7'd3,  32'h0,        0, FWD ? 0 : 1, FWD ? 1 : RL};
    vecs[6] = '{1'b0, 7'd3,  32'h0,        4, 0,           RL};
    vecs[7] = '{1'b1, 7'd10, 32'hA5A5A5A5, 3, 0,           -1};
    vecs[8] = '{1'b0, 7'd11, 32'h0,        0, 0,           RL};
    vecs[9] = '{1'b0, 7'd10, 32'h0,        0, FWD ? 2 : 3, FWD ? 1 : RL};
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].gap, vecs[i].exp_wait, vecs[i].exp_lat);
      if (i == 0) begin
        idle(1);
        check("t1_sb_empty_a", DW'(sb_empty), 1);
        idle(1);
        check("t1_sb_empty_b", DW'(sb_empty), 1);
      end
    end

    // Random traffic over a small address window to stress ordering.
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
             $urandom_range(0, 2), -1, -1);
    end

    // Back-to-back stores across pointer wrap: each accept pairs with a drain.
    idle(6);
    for (int i = 0; i < 9; i++) begin
      do_req(1'b1, AW'(40 + i), $urandom(), 0, 0, -1);
    end
    @(negedge clk);
    check("wrap_count_hold", DW'(sb_count), 1);
    @(negedge clk);
    check("wrap_count_empty", DW'(sb_count), 0);
    check("wrap_sb_empty", DW'(sb_empty), 1);
    for (int i = 0; i < 9; i++) begin
      do_req(1'b0, AW'(40 + i), '0, RL, 0, RL);
    end

    // Miss with a pending store: drain pauses while the read is in flight.
    idle(6);
    do_req(1'b1, 7'd1, 32'hCAFE0001, 0, 0, -1);
    do_req(1'b0, 7'd9, '0, 0, 0, RL);
    @(negedge clk);
    check("busy1_state", DW'(dbg_state), 1);
    check("busy1_count", DW'(sb_count), 1);
    @(negedge clk);
    check("busy2_state", DW'(dbg_state), 1);
    check("busy2_count", DW'(sb_count), 1);
    @(negedge clk);
    check("post_busy_state", DW'(dbg_state), 0);
    check("post_busy_count", DW'(sb_count), 1);
    @(negedge clk);
    check("drained_count", DW'(sb_count), 0);
    do_req(1'b0, 7'd1, '0, 0, 0, RL);

    // Reset while a read is in flight: the response and the buffered store are lost.
    idle(6);
    do_req(1'b1, 7'd30, 32'h55AA55AA, 0, 0, -1);
    do_req(1'b0, 7'd60, '0, 0, 0, RL);
    @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    void'(care_q.pop_back());
    void'(cyc_q.pop_back());
    ref_known[30] = 1'b0;
    idle(2);
    rst_n = 1'b1;
    #1;
    check("midrst_req_ready", DW'(bus.req_ready), 1);
    check("midrst_state", DW'(dbg_state), 0);
    check("midrst_count", DW'(sb_count), 0);
    check("midrst_rsp_valid", DW'(bus.rsp_valid), 0);
    idle(RL + 3);
    do_req(1'b1, 7'd31, 32'h13572468, 0, 0, -1);
    do_req(1'b0, 7'd31, '0, 0, FWD ? 0 : 1, FWD ? 1 : RL);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    idle(2);
    check("queue_empty", DW'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
